// File: rtl/alu_pkg.sv
// Shared ALU control codes and EX-stage FSM state type.
// ALU_MULT_EN selects whether code 1000 runs the iterative multiply.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_INV = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ex_state_t;

endpackage

// File: rtl/ex_alu_stage_mul.sv
// Iterative shift-add multiplier, one multiplier bit per step.
// Built only when ALU_MULT_EN is defined; yields the low WIDTH product bits.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] addend;

    assign addend = mplier_q[0] ? mcand_q : '0;
    // Final step's partial sum is presented directly so completion needs no extra cycle
    assign prod_o = acc_q + addend;
    assign done_o = step_i && (cnt_q == LAST);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_q + addend;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_alu_stage.sv
// EX-stage ALU with valid/ready handshake into the EX/MEM register.
// ALU_MULT_EN enables the multi-cycle multiply (code 1000); otherwise 1000 is illegal.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RDW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [RDW-1:0]   in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RDW-1:0]   out_rd,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    ex_state_t        state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [RDW-1:0]   rd_q, rd_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic             is_add, is_sub, is_and, is_or, is_slt;
    logic [WIDTH-1:0] b_eff, sum, alu_res;
    logic             alu_ovf, alu_ill;
    logic             accept;

    assign is_add = (alu_ctrl == ALU_ADD);
    assign is_sub = (alu_ctrl == ALU_SUB);
    assign is_and = (alu_ctrl == ALU_AND);
    assign is_or  = (alu_ctrl == ALU_OR);
    assign is_slt = (alu_ctrl == ALU_SLT);

    // Subtract shares the adder: a + ~b + 1
    assign b_eff = is_sub ? ~op_b : op_b;
    assign sum   = op_a + b_eff + WIDTH'(is_sub);

`ifdef ALU_MULT_EN
    logic             is_mul;
    logic             mul_start, mul_step, mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic [RDW-1:0]   prd_q, prd_d;

    assign is_mul = (alu_ctrl == ALU_MUL);

    mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start_i (mul_start),
        .step_i  (mul_step),
        .a_i     (op_a),
        .b_i     (op_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`endif

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        unique case (1'b1)
            is_add, is_sub: begin
                alu_res = sum;
                alu_ovf = (op_a[MSB] == b_eff[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            is_and: alu_res = op_a & op_b;
            is_or:  alu_res = op_a | op_b;
            is_slt: alu_res = WIDTH'($signed(op_a) < $signed(op_b));
`ifdef ALU_MULT_EN
            is_mul: alu_res = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    assign in_ready = (state_q == IDLE) && (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        res_d   = res_q;
        rd_d    = rd_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
`ifdef ALU_MULT_EN
        prd_d     = prd_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
`endif
        if (flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (out_ready) valid_d = 1'b0;
`ifdef ALU_MULT_EN
                    // Output register drains here, so the final load never stalls
                    if (accept && is_mul) begin
                        state_d   = MUL;
                        valid_d   = 1'b0;
                        prd_d     = in_rd;
                        mul_start = 1'b1;
                    end else
`endif
                    if (accept) begin
                        valid_d = 1'b1;
                        res_d   = alu_res;
                        rd_d    = in_rd;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        ill_d   = alu_ill;
                    end
                end
`ifdef ALU_MULT_EN
                MUL: begin
                    mul_step = 1'b1;
                    if (mul_done) begin
                        state_d = IDLE;
                        valid_d = 1'b1;
                        res_d   = mul_prod;
                        rd_d    = prd_q;
                        zero_d  = (mul_prod == '0);
                        ovf_d   = 1'b0;
                        ill_d   = 1'b0;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

`ifdef ALU_MULT_EN
    always_ff @(posedge clk) begin
        if (reset) prd_q <= '0;
        else       prd_q <= prd_d;
    end

    assign busy = (state_q == MUL);
`else
    assign busy = 1'b0;
`endif

    assign out_valid   = valid_q;
    assign out_result  = res_q;
    assign out_rd      = rd_q;
    assign out_zero    = zero_q;
    assign out_ovf     = ovf_q;
    assign out_illegal = ill_q;

endmodule
